// File: rtl/rpn_engine_if.sv
// Token channel into the RPN engine: valid/ready handshake carrying an opcode
// and an immediate operand.
interface rpn_engine_if #(
    parameter int unsigned D = 32
);
    logic         valid;
    logic         ready;
    logic [2:0]   op;
    logic [D-1:0] data;

    modport master (output valid, output op, output data, input ready);
    modport slave  (input valid, input op, input data, output ready);
endinterface

// File: rtl/rpn_engine.sv
// Reverse-Polish evaluation engine driving an external LIFO stack; tracks depth
// locally and turns illegal tokens into a sticky first-error-wins flag.
module rpn_engine #(
    parameter int unsigned D = 32,
    parameter int unsigned A = 4
) (
    input  logic         clk,
    input  logic         reset,
    rpn_engine_if.slave  tok,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [D-1:0] stk_wr_data,
    input  logic [D-1:0] stk_rd_data,
    output logic         res_valid,
    output logic [D-1:0] res_data,
    output logic [A:0]   depth,
    output logic         err,
    output logic [1:0]   err_code,
    input  logic         err_clr
);
    localparam logic [2:0] OpPush = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpAnd  = 3'b011;
    localparam logic [2:0] OpOr   = 3'b100;
    localparam logic [2:0] OpXor  = 3'b101;
    localparam logic [2:0] OpDup  = 3'b110;
    localparam logic [2:0] OpEmit = 3'b111;

    localparam logic [1:0] ErrNone = 2'b00;
    localparam logic [1:0] ErrUnf  = 2'b01;
    localparam logic [1:0] ErrOvf  = 2'b10;

    localparam logic [A:0] Full = {1'b1, {A{1'b0}}};
    localparam logic [A:0] One  = {{A{1'b0}}, 1'b1};
    localparam logic [A:0] Two  = {{(A-1){1'b0}}, 2'b10};

    typedef enum logic [2:0] {StIdle, StPop1, StPop2, StWrite, StEmit} state_e;

    state_e       state;
    logic [2:0]   op_q;
    logic [D-1:0] data_q;
    logic [D-1:0] opa_q;
    logic [D-1:0] opb_q;
    logic [1:0]   cause;

    assign tok.ready = (state == StIdle);
    assign stk_push  = (state == StWrite);
    assign stk_pop   = (state == StPop1) || (state == StPop2) || (state == StEmit);

    always_comb begin
        cause = ErrNone;
        case (tok.op)
            OpPush: if (depth == Full) cause = ErrOvf;
            OpDup: begin
                if (depth == '0) cause = ErrUnf;
                else if (depth == Full) cause = ErrOvf;
            end
            OpEmit: if (depth == '0) cause = ErrUnf;
            default: if (depth < Two) cause = ErrUnf;
        endcase
    end

    // opa is the old top, opb the entry beneath it, so SUB yields second - top.
    always_comb begin
        case (op_q)
            OpAdd:   stk_wr_data = opb_q + opa_q;
            OpSub:   stk_wr_data = opb_q - opa_q;
            OpAnd:   stk_wr_data = opb_q & opa_q;
            OpOr:    stk_wr_data = opb_q | opa_q;
            OpXor:   stk_wr_data = opb_q ^ opa_q;
            default: stk_wr_data = data_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            op_q      <= OpPush;
            data_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            depth     <= '0;
            err       <= 1'b0;
            err_code  <= ErrNone;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (err_clr) begin
                err      <= 1'b0;
                err_code <= ErrNone;
            end
            case (state)
                StIdle: begin
                    if (tok.valid) begin
                        if (cause != ErrNone) begin
                            // A clear on the same edge lets the new error take over.
                            if (!err || err_clr) begin
                                err      <= 1'b1;
                                err_code <= cause;
                            end
                        end else begin
                            op_q <= tok.op;
                            case (tok.op)
                                OpPush: begin
                                    data_q <= tok.data;
                                    state  <= StWrite;
                                end
                                OpDup: begin
                                    data_q <= stk_rd_data;
                                    state  <= StWrite;
                                end
                                OpEmit:  state <= StEmit;
                                default: state <= StPop1;
                            endcase
                        end
                    end
                end
                StPop1: begin
                    opa_q <= stk_rd_data;
                    depth <= depth - One;
                    state <= StPop2;
                end
                StPop2: begin
                    opb_q <= stk_rd_data;
                    depth <= depth - One;
                    state <= StWrite;
                end
                StWrite: begin
                    depth <= depth + One;
                    state <= StIdle;
                end
                StEmit: begin
                    res_data  <= stk_rd_data;
                    res_valid <= 1'b1;
                    depth     <= depth - One;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
